// File: rtl/jpeg_tp_pkg.sv
// Shared constants and helpers for the DCT-path transpose buffer.
package jpeg_tp_pkg;

    // Block dimension and element width for the stage-1 to stage-2 hop
    localparam int unsigned TP_N          = 8;
    localparam int unsigned TP_ELEM_W     = 9;
    // Element width for the stage-2 to quantiser hop
    localparam int unsigned ELEM_W_STAGE2 = 10;

    // Counter width for a 0..value-1 range; never narrower than one bit
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/tp_bank.sv
// One N x N element bank: whole-row write port, combinational row/column read port.
module tp_bank
    import jpeg_tp_pkg::*;
#(
    parameter int unsigned N      = TP_N,
    parameter int unsigned ELEM_W = TP_ELEM_W
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [clog2(N)-1:0]       wr_row,
    input  logic [N*ELEM_W-1:0]       wr_data,
    input  logic [clog2(N)-1:0]       rd_idx,
    input  logic                      rd_tp,
    output logic [N*ELEM_W-1:0]       rd_data
);

    logic [ELEM_W-1:0] mem [N][N];

    // Storage is deliberately not reset; the owner's full flag qualifies it
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < int'(N); c++) begin
                mem[wr_row][c] <= wr_data[c*ELEM_W +: ELEM_W];
            end
        end
    end

    // Transpose reads column rd_idx across all rows; pass-through reads row rd_idx
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            rd_data[i*ELEM_W +: ELEM_W] = rd_tp ? mem[i][rd_idx] : mem[rd_idx][i];
        end
    end

endmodule

// File: rtl/tp_pingpong_buf.sv
// Ping-pong transpose buffer: rows fill one bank while the other drains columns.
// Optional block-end marker passthrough is built when TP_LAST_EN is defined.
module tp_pingpong_buf
    import jpeg_tp_pkg::*;
#(
    parameter int unsigned N      = TP_N,
    parameter int unsigned ELEM_W = TP_ELEM_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*ELEM_W-1:0]   in_data,
    input  logic                  in_tp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*ELEM_W-1:0]   out_data
`ifdef TP_LAST_EN
    ,
    input  logic                  in_last,
    output logic                  out_last
`endif
);

    localparam int unsigned CW   = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic          wr_bank;
    logic          rd_bank;
    logic [CW-1:0] wr_row;
    logic [CW-1:0] rd_idx;
    logic [1:0]    full;
    logic [1:0]    mode;
    logic          wr_fire;
    logic          rd_fire;
    logic [N*ELEM_W-1:0] rd_data0;
    logic [N*ELEM_W-1:0] rd_data1;

    // Handshakes are qualified only by registered flags, so a freed bank opens next cycle
    always_comb begin
        in_ready  = !full[wr_bank] && !clear;
        out_valid = full[rd_bank];
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid && out_ready;
        out_data  = rd_bank ? rd_data1 : rd_data0;
    end

    // Pointer, counter and per-bank flag update; write and read sides never touch the same bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_idx  <= '0;
            full    <= '0;
            mode    <= '0;
        end else if (clear) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_row  <= '0;
            rd_idx  <= '0;
            full    <= '0;
            mode    <= '0;
        end else begin
            if (wr_fire) begin
                if (wr_row == '0) begin
                    mode[wr_bank] <= in_tp;
                end
                if (wr_row == LAST) begin
                    wr_row        <= '0;
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_idx == LAST) begin
                    rd_idx        <= '0;
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

`ifdef TP_LAST_EN
    logic [1:0] last_flag;

    // Block-end marker captured with the final row of each bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_flag <= '0;
        end else if (clear) begin
            last_flag <= '0;
        end else if (wr_fire && wr_row == LAST) begin
            last_flag[wr_bank] <= in_last;
        end
    end

    // Marker accompanies only the final vector of the block
    always_comb begin
        out_last = last_flag[rd_bank] && (rd_idx == LAST) && out_valid;
    end
`endif

    tp_bank #(
        .N      (N),
        .ELEM_W (ELEM_W)
    ) u_bank0 (
        .clk     (clk),
        .wr_en   (wr_fire && !wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_data),
        .rd_idx  (rd_idx),
        .rd_tp   (mode[0]),
        .rd_data (rd_data0)
    );

    tp_bank #(
        .N      (N),
        .ELEM_W (ELEM_W)
    ) u_bank1 (
        .clk     (clk),
        .wr_en   (wr_fire && wr_bank),
        .wr_row  (wr_row),
        .wr_data (in_data),
        .rd_idx  (rd_idx),
        .rd_tp   (mode[1]),
        .rd_data (rd_data1)
    );

endmodule

// File: tb/tb_tp_pingpong_buf.sv
// Scoreboard bench for tp_pingpong_buf; exercises out_last when TP_LAST_EN is defined.
module tb_tp_pingpong_buf;

    localparam int unsigned N  = 8;
    localparam int unsigned EW = 9;
    localparam int unsigned VW = N * EW;

    typedef struct packed {
        logic [VW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_tp = 1'b0;
    logic          out_ready = 1'b0;
    logic [VW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [VW-1:0] out_data;
`ifdef TP_LAST_EN
    logic          in_last = 1'b0;
    logic          out_last;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   seg_cnt = 0;
    int   seg_first = 0;
    int   seg_last = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model of the block being assembled
    logic [VW-1:0] m_blk [N];
    int            m_row = 0;
    logic          m_tp = 1'b0;

    tp_pingpong_buf #(
        .N      (N),
        .ELEM_W (EW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tp     (in_tp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef TP_LAST_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output scoreboard: a handshake seen here completes on the next rising edge
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output got=%h want=<none>", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data) begin
                    n_err++;
                    $display("FAIL out_data got=%h want=%h", out_data, mon_e.data);
                end
`ifdef TP_LAST_EN
                if (out_last !== mon_e.last) begin
                    n_err++;
                    $display("FAIL out_last got=%b want=%b", out_last, mon_e.last);
                end
`endif
            end
            if (seg_cnt == 0) seg_first = cyc;
            seg_last = cyc;
            seg_cnt++;
        end
    end

    function automatic logic [VW-1:0] seq_row(input int base);
        logic [VW-1:0] r;
        for (int c = 0; c < int'(N); c++) r[c*EW +: EW] = EW'(base + c);
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_row();
        logic [VW-1:0] r;
        for (int c = 0; c < int'(N); c++) r[c*EW +: EW] = EW'($urandom);
        return r;
    endfunction

    // Model: a completed block pushes its N expected vectors
    task automatic model_accept(input logic [VW-1:0] d, input logic tp, input logic last);
        exp_t e;
        if (m_row == 0) m_tp = tp;
        m_blk[m_row] = d;
        if (m_row == int'(N) - 1) begin
            for (int k = 0; k < int'(N); k++) begin
                if (m_tp) begin
                    for (int i = 0; i < int'(N); i++) e.data[i*EW +: EW] = m_blk[i][k*EW +: EW];
                end else begin
                    e.data = m_blk[k];
                end
                e.last = last && (k == int'(N) - 1);
                exp_q.push_back(e);
            end
            m_row = 0;
        end else begin
            m_row++;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the row handshake
    task automatic send_row(input logic [VW-1:0] d, input logic tp, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_tp    = tp;
`ifdef TP_LAST_EN
        in_last  = last;
`endif
        @(negedge clk);
        while (!in_ready) begin
            stall_cnt++;
            waited++;
            if (waited > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL send_row_timeout in_ready=%b want=1", in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        model_accept(d, tp, last);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        for (int r = 0; r < int'(N); r++) begin
            send_row(seq_row(8 * r), 1'b1, 1'b0);
            if (r == int'(N) - 2) begin
                n_vec++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL early_valid got=%b want=0", out_valid);
                end
            end
        end
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL latency_valid got=%b want=1", out_valid);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        stall_cnt = 0;
        seg_cnt   = 0;
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < int'(N); r++) send_row(seq_row(64 * b + 8 * r), 1'b1, 1'b0);
        end
        wait_drain();
        n_vec++;
        if (stall_cnt != 0) begin
            n_err++;
            $display("FAIL stream_in_ready stalls=%0d want=0", stall_cnt);
        end
        n_vec++;
        if (seg_cnt != 32 || seg_last - seg_first != 31) begin
            n_err++;
            $display("FAIL stream_contig count=%0d span=%0d want 32/31", seg_cnt,
                     seg_last - seg_first);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int r = 0; r < 2 * int'(N); r++) send_row(rand_row(), 1'b1, 1'b0);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full in_ready=%b want=0", in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < int'(N); k++) begin
            @(negedge clk);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_ready_low k=%0d in_ready=%b want=0", k, in_ready);
            end
        end
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_back in_ready=%b want=1", in_ready);
        end
        wait_drain();
    endtask

    task automatic test_mode();
        out_ready = 1'b1;
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), (r == 0), 1'b0);
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), (r != 0), 1'b0);
        wait_drain();
    endtask

    task automatic test_clear();
        int bad = 0;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) send_row(rand_row(), 1'b1, 1'b0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_row();
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clear_ready in_ready=%b want=0", in_ready);
        end
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        m_row    = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL clear_no_valid cycles=%0d want=0", bad);
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), 1'b1, 1'b0);
        wait_drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), 1'b1, 1'b0);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        exp_q.delete();
        m_row = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), 1'b0, 1'b0);
        wait_drain();
    endtask

`ifdef TP_LAST_EN
    task automatic test_last();
        out_ready = 1'b1;
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), 1'b1, (r == int'(N) - 1));
        for (int r = 0; r < int'(N); r++) send_row(rand_row(), 1'b1, (r == 3));
        wait_drain();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mode();
        test_clear();
        test_async_reset();
`ifdef TP_LAST_EN
        test_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
